snes_ctrlr: RTL
===============

Name: snes_ctrlr

Overview:
- Peripheral that answers CPU controller reads (ctrlr_re / addr_ctrlr / din_ctrlrs) issued by the memory controller.
- Autonomously polls two SNES gamepads over the serial latch/clock/data protocol.
- Holds de-serialized, active-high button words plus a status register for the CPU to read at any time.

Parameters:
- CLK_DIV, 300, system clocks per half SNES clock period (6 us at 50 MHz); minimum 1.
- POLL_PERIOD, 833333, system clocks between poll starts (60 Hz); must exceed 34*CLK_DIV+4.
- DATAWIDTH, 16, CPU data bus width; fixed at 16.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active low
- ctrlr_re  input  1  CPU read strobe from memory controller
- addr_ctrlr  input  2  register select: 0 = pad0, 1 = pad1, 2 = status, 3 = edge/zero
- din_ctrlrs  output  16  read data to CPU
- snes_latch  output  1  latch to both pads, active high
- snes_clk  output  1  serial clock to both pads, idle high
- snes_data0  input  1  serial data from pad0, button pressed = 0
- snes_data1  input  1  serial data from pad1, button pressed = 0

Behaviour:
- Reset values (async, while rst=0):
  - snes_latch=0, snes_clk=1, din_ctrlrs=0.
  - pad0/pad1 regs=0, shift regs=0, new_data=0, state=IDLE, poll timer=0, bit count=0.
- Poll timer: free-runs 0..POLL_PERIOD-1, then wraps to 0. First poll starts POLL_PERIOD cycles after reset release.
- State machine:
  - IDLE: when timer==POLL_PERIOD-1, go to LATCH.
  - LATCH: snes_latch=1 for 2*CLK_DIV cycles, then go to CLK_LO with bit count=0.
  - CLK_LO: snes_clk=0 for CLK_DIV cycles. On the final cycle, sample snes_data0/1 into shift reg bit [count]. Go to CLK_HI.
  - CLK_HI: snes_clk=1 for CLK_DIV cycles. If count==15, go to DONE; else count+1 and go back to CLK_LO.
  - DONE: 1 cycle. pad0 <= ~shift0, pad1 <= ~shift1 (atomic, both in the same cycle), new_data <= 1. Then go to IDLE.
- Bit order: bit 0 = first bit after latch (B), then Y, Select, Start, Up, Down, Left, Right, A, X, L, R. Bits 12-15 read 0 with a real pad.
- A timer wrap during an active poll is ignored; there is no restart and no queued poll.
- Half-period counter: 0..CLK_DIV-1, cleared on each state change.
- Read path (combinational from registers):
  - din_ctrlrs = selected register while ctrlr_re=1, else 0.
  - Status register: bit0 = new_data, bit1 = busy (state != IDLE), bits 15:2 = 0.
- Status clear-on-read: on a rising edge with ctrlr_re=1 and addr_ctrlr=2, new_data clears.
  - If DONE occurs in the same cycle, new_data stays 1 (set wins).
  - The read returns the pre-edge value.
- Reads of pad0/pad1 during a poll return the previous complete word; partial shifts are never visible.
- Reset mid-poll: outputs return to reset values immediately and the partially shifted data is discarded.

Optional Feature:
- Macro SNES_EDGE_EN.
- Defined:
  - addr 3 returns edge0, a 16-bit sticky register. In DONE, edge0 <= edge0 | (~shift0 & ~pad0_old).
  - edge0 clears on a rising edge with ctrlr_re=1 and addr_ctrlr=3. A same-cycle DONE keeps the newly set bits (set wins per bit).
  - Reset value 0.
- Undefined: addr 3 reads 0, and no edge register is built.

Test Plan:
- Reset/idle: CLK_DIV=2, POLL_PERIOD=100; hold rst=0 then release → latch=0, clk=1, all reads 0; first snes_latch rise exactly 100 cycles after release, high 4 cycles.
- Serial frame: pad0 model drives 16'hF5A5 raw, pad1 drives 16'hFFFE → 16 clk low pulses of 2 cycles each; after DONE, addr0 reads 16'h0A5A, addr1 reads 16'h0001; status reads 16'h0001 after the poll.
- Clear-on-read: read addr2 → 16'h0001 returned, next read 16'h0000; read addr2 in the exact DONE cycle of the next poll → new_data remains 1.
- Atomic update: change pad0 data to all-pressed mid-frame while reading addr0 every cycle → value jumps from old word to 16'h0FFF in one step, no intermediate values; status bit1=1 throughout the frame.
- Reset mid-poll: assert rst at bit 7 → latch=0, clk=1 asynchronously, pad regs 0; after release, no pulses until timer reaches 99.
- SNES_EDGE_EN: pad0 A pressed (raw bit8=0) on poll 2 only → addr3 reads 16'h0100, second read 16'h0000; without the macro, addr3 always reads 0.

Source files
------------

// File: rtl/snes_ctrlr.sv
// SNES dual-gamepad poller with a CPU read port: pad0, pad1, status, and (with
// SNES_EDGE_EN defined) a sticky newly-pressed register for pad0 at address 3.
module snes_ctrlr #(
    parameter int CLK_DIV     = 300,
    parameter int POLL_PERIOD = 833333,
    parameter int DATAWIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrlr_re,
    input  logic [1:0]           addr_ctrlr,
    output logic [DATAWIDTH-1:0] din_ctrlrs,
    output logic                 snes_latch,
    output logic                 snes_clk,
    input  logic                 snes_data0,
    input  logic                 snes_data1
);

    localparam int TIMER_W = $clog2(POLL_PERIOD);
    localparam int HALF_W  = $clog2(2 * CLK_DIV);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_PERIOD - 1);
    localparam logic [HALF_W-1:0]  LATCH_LAST = HALF_W'(2 * CLK_DIV - 1);
    localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LO,
        CLK_HI,
        DONE
    } state_t;

    state_t               state;
    logic [TIMER_W-1:0]   timer;
    logic [HALF_W-1:0]    half_cnt;
    logic [3:0]           bit_cnt;
    logic [DATAWIDTH-1:0] shift0;
    logic [DATAWIDTH-1:0] shift1;
    logic [DATAWIDTH-1:0] pad0;
    logic [DATAWIDTH-1:0] pad1;
    logic                 new_data;
    logic                 busy;
    logic                 status_rd;

    assign busy      = (state != IDLE);
    assign status_rd = ctrlr_re && (addr_ctrlr == 2'd2);

`ifdef SNES_EDGE_EN
    logic [DATAWIDTH-1:0] edge0;
    logic                 edge_rd;

    assign edge_rd = ctrlr_re && (addr_ctrlr == 2'd3);
`endif

    // Free-running poll timer; the FSM only looks at it while idle, so a wrap
    // during an active poll is simply ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (timer == TIMER_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; where a clear and
    // a set both hit a register in one cycle, the later assignment (the set)
    // wins, which gives the set-over-clear priority the read port needs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            shift0     <= '0;
            shift1     <= '0;
            pad0       <= '0;
            pad1       <= '0;
            new_data   <= 1'b0;
            snes_latch <= 1'b0;
            snes_clk   <= 1'b1;
`ifdef SNES_EDGE_EN
            edge0      <= '0;
`endif
        end else begin
            if (status_rd) begin
                new_data <= 1'b0;
            end
`ifdef SNES_EDGE_EN
            if (edge_rd) begin
                edge0 <= '0;
            end
`endif
            case (state)
                IDLE: begin
                    if (timer == TIMER_LAST) begin
                        state      <= LATCH;
                        snes_latch <= 1'b1;
                        half_cnt   <= '0;
                    end
                end

                LATCH: begin
                    if (half_cnt == LATCH_LAST) begin
                        state      <= CLK_LO;
                        snes_latch <= 1'b0;
                        snes_clk   <= 1'b0;
                        half_cnt   <= '0;
                        bit_cnt    <= '0;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end

                // Sample on the last low cycle, just before snes_clk rises and
                // the pads shift out their next bit.
                CLK_LO: begin
                    if (half_cnt == HALF_LAST) begin
                        shift0[bit_cnt] <= snes_data0;
                        shift1[bit_cnt] <= snes_data1;
                        state           <= CLK_HI;
                        snes_clk        <= 1'b1;
                        half_cnt        <= '0;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end

                CLK_HI: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        if (bit_cnt == 4'd15) begin
                            state <= DONE;
                        end else begin
                            state    <= CLK_LO;
                            snes_clk <= 1'b0;
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end

                // Both words commit together so the CPU never sees a half-updated pair.
                DONE: begin
                    pad0     <= ~shift0;
                    pad1     <= ~shift1;
                    new_data <= 1'b1;
`ifdef SNES_EDGE_EN
                    edge0    <= (edge_rd ? '0 : edge0) | (~shift0 & ~pad0);
`endif
                    state    <= IDLE;
                    half_cnt <= '0;
                end

                default: begin
                    state      <= IDLE;
                    half_cnt   <= '0;
                    snes_latch <= 1'b0;
                    snes_clk   <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: the read mux assigns a default first so no path infers a latch.
    always_comb begin
        din_ctrlrs = '0;
        if (ctrlr_re) begin
            case (addr_ctrlr)
                2'd0:    din_ctrlrs = pad0;
                2'd1:    din_ctrlrs = pad1;
                2'd2:    din_ctrlrs = {{(DATAWIDTH-2){1'b0}}, busy, new_data};
`ifdef SNES_EDGE_EN
                default: din_ctrlrs = edge0;
`else
                default: din_ctrlrs = '0;
`endif
            endcase
        end
    end

endmodule
